// File: rtl/hub75_scan_driver_if.sv
// Read port between the HUB75 scan driver and the dual-buffer pixel RAM.
// The driver is the master: it issues the address and enable, and the RAM returns the data.
interface hub75_scan_driver_if #(
    parameter int BITS_PER_PIXEL = 32
);
    logic [9:0]                read_addr;
    logic                      read_en;
    logic [BITS_PER_PIXEL-1:0] read_data_top;
    logic [BITS_PER_PIXEL-1:0] read_data_bottom;

    modport master (
        output read_addr,
        output read_en,
        input  read_data_top,
        input  read_data_bottom
    );

    modport slave (
        input  read_addr,
        input  read_en,
        output read_data_top,
        output read_data_bottom
    );
endinterface

// File: rtl/hub75_scan_driver.sv
// HUB75 64x32 scan driver: shifts row pairs out of the frame buffer with binary-coded
// modulation and swaps the displayed buffer only at a frame boundary.
module hub75_scan_driver #(
    parameter int BITS_PER_PIXEL   = 32,
    parameter int BITS_PER_CHANNEL = 8,
    parameter int BASE_CYCLES      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    hub75_scan_driver_if.master        ram,
    output logic                       buffer_toggle,
    input  logic                       swap_req,
    output logic                       swap_ack,
    output logic                       hub75_r0,
    output logic                       hub75_g0,
    output logic                       hub75_b0,
    output logic                       hub75_r1,
    output logic                       hub75_g1,
    output logic                       hub75_b1,
    output logic                       hub75_clk,
    output logic                       hub75_lat,
    output logic                       hub75_oe_n,
    output logic [3:0]                 hub75_addr
);
    localparam int PLANE_W     = (BITS_PER_CHANNEL > 1) ? $clog2(BITS_PER_CHANNEL) : 1;
    localparam int MAX_DISPLAY = BASE_CYCLES << (BITS_PER_CHANNEL - 1);
    localparam int DISP_W      = $clog2(MAX_DISPLAY + 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BITS_PER_CHANNEL - 1);

    typedef enum logic [2:0] {
        S_READ,
        S_DATA,
        S_CLK,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t              state, state_n;
    logic [3:0]          row, row_n;
    logic [5:0]          col, col_n;
    logic [PLANE_W-1:0]  plane, plane_n;
    logic [DISP_W-1:0]   disp_cnt, disp_cnt_n;
    logic                swap_pending, swap_pending_n;
    logic                toggle_n, ack_n, frame_end;
    logic [5:0]          colour, colour_n;   // {r0, g0, b0, r1, g1, b1}
    logic [3:0]          addr_n;

    logic [BITS_PER_CHANNEL-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;
    assign top_r = ram.read_data_top[BITS_PER_CHANNEL-1:0];
    assign top_g = ram.read_data_top[2*BITS_PER_CHANNEL-1:BITS_PER_CHANNEL];
    assign top_b = ram.read_data_top[3*BITS_PER_CHANNEL-1:2*BITS_PER_CHANNEL];
    assign bot_r = ram.read_data_bottom[BITS_PER_CHANNEL-1:0];
    assign bot_g = ram.read_data_bottom[2*BITS_PER_CHANNEL-1:BITS_PER_CHANNEL];
    assign bot_b = ram.read_data_bottom[3*BITS_PER_CHANNEL-1:2*BITS_PER_CHANNEL];

    // Pixel bits above the three colour channels carry no display information.
    logic unused_ram_bits;
    assign unused_ram_bits = ^{ram.read_data_top, ram.read_data_bottom};

    assign {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1} = colour;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_n        = state;
        row_n          = row;
        col_n          = col;
        plane_n        = plane;
        disp_cnt_n     = disp_cnt;
        colour_n       = colour;
        addr_n         = hub75_addr;
        swap_pending_n = swap_pending | swap_req;
        toggle_n       = buffer_toggle;
        ack_n          = 1'b0;
        frame_end      = 1'b0;

        case (state)
            // Straight out of reset read_en is still low, so spend one cycle issuing the read.
            S_READ:  state_n = ram.read_en ? S_DATA : S_READ;
            S_DATA: begin
                colour_n = {top_r[plane], top_g[plane], top_b[plane],
                            bot_r[plane], bot_g[plane], bot_b[plane]};
                state_n  = S_CLK;
            end
            S_CLK: begin
                col_n   = col + 6'd1;
                state_n = (col == 6'd63) ? S_BLANK : S_READ;
            end
            S_BLANK: begin
                addr_n  = row;
                state_n = S_LATCH;
            end
            S_LATCH: begin
                disp_cnt_n = DISP_W'((BASE_CYCLES << plane) - 1);
                state_n    = S_DISPLAY;
            end
            S_DISPLAY: begin
                if (disp_cnt == '0) begin
                    state_n = S_READ;
                    if (plane == LAST_PLANE) begin
                        plane_n   = '0;
                        row_n     = row + 4'd1;
                        frame_end = (row == 4'd15);
                    end else begin
                        plane_n = plane + PLANE_W'(1);
                    end
                end else begin
                    disp_cnt_n = disp_cnt - DISP_W'(1);
                end
            end
            default: state_n = S_READ;
        endcase

        // A request arriving in the frame-end cycle is consumed here rather than lost.
        if (frame_end && swap_pending_n) begin
            toggle_n       = ~buffer_toggle;
            ack_n          = 1'b1;
            swap_pending_n = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_READ;
            row           <= '0;
            col           <= '0;
            plane         <= '0;
            disp_cnt      <= '0;
            swap_pending  <= 1'b0;
            buffer_toggle <= 1'b0;
            swap_ack      <= 1'b0;
            colour        <= '0;
            ram.read_en   <= 1'b0;
            ram.read_addr <= '0;
            hub75_clk     <= 1'b0;
            hub75_lat     <= 1'b0;
            hub75_oe_n    <= 1'b1;
            hub75_addr    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state         <= state_n;
            row           <= row_n;
            col           <= col_n;
            plane         <= plane_n;
            disp_cnt      <= disp_cnt_n;
            swap_pending  <= swap_pending_n;
            buffer_toggle <= toggle_n;
            swap_ack      <= ack_n;
            colour        <= colour_n;
            ram.read_en   <= (state_n == S_READ);
            ram.read_addr <= {row_n, col_n};
            hub75_clk     <= (state_n == S_CLK);
            hub75_lat     <= (state_n == S_LATCH);
            hub75_oe_n    <= (state_n != S_DISPLAY);
            hub75_addr    <= addr_n;
        end
    end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: a default-sized panel for shift/BCM/frame timing and a
// reduced-depth instance (2 planes, 1-cycle base) for random pixels and buffer swaps.
`timescale 1ns/1ps
module tb_hub75_scan_driver;
    localparam int BPP     = 32;
    localparam int BPC_B   = 8;
    localparam int BASE_B  = 4;
    localparam int BPC_S   = 2;
    localparam int BASE_S  = 1;
    localparam int FRAME_B = 41152;
    localparam int FRAME_S = 16 * (BPC_S * (64 * 3 + 2) + BASE_S * ((1 << BPC_S) - 1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, reset_s_n;
    logic swap_req_b, swap_req_s;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    hub75_scan_driver_if #(.BITS_PER_PIXEL(BPP)) ram_b ();
    hub75_scan_driver_if #(.BITS_PER_PIXEL(BPP)) ram_s ();

    logic       toggle_b, ack_b, r0_b, g0_b, b0_b, r1_b, g1_b, b1_b, hclk_b, lat_b, oe_b;
    logic [3:0] addr_b;
    logic       toggle_s, ack_s, r0_s, g0_s, b0_s, r1_s, g1_s, b1_s, hclk_s, lat_s, oe_s;
    logic [3:0] addr_s;

    hub75_scan_driver #(.BITS_PER_PIXEL(BPP), .BITS_PER_CHANNEL(BPC_B), .BASE_CYCLES(BASE_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .ram(ram_b.master),
        .buffer_toggle(toggle_b), .swap_req(swap_req_b), .swap_ack(ack_b),
        .hub75_r0(r0_b), .hub75_g0(g0_b), .hub75_b0(b0_b),
        .hub75_r1(r1_b), .hub75_g1(g1_b), .hub75_b1(b1_b),
        .hub75_clk(hclk_b), .hub75_lat(lat_b), .hub75_oe_n(oe_b), .hub75_addr(addr_b)
    );

    hub75_scan_driver #(.BITS_PER_PIXEL(BPP), .BITS_PER_CHANNEL(BPC_S), .BASE_CYCLES(BASE_S)) dut_s (
        .clk(clk), .reset_n(reset_s_n), .ram(ram_s.master),
        .buffer_toggle(toggle_s), .swap_req(swap_req_s), .swap_ack(ack_s),
        .hub75_r0(r0_s), .hub75_g0(g0_s), .hub75_b0(b0_s),
        .hub75_r1(r1_s), .hub75_g1(g1_s), .hub75_b1(b1_s),
        .hub75_clk(hclk_s), .hub75_lat(lat_s), .hub75_oe_n(oe_s), .hub75_addr(addr_s)
    );

    // RAM models with one cycle of read latency; both buffers hold the same picture.
    logic [BPP-1:0] mem_s_top [1024];
    logic [BPP-1:0] mem_s_bot [1024];
    always @(posedge clk) begin
        if (ram_b.read_en) begin
            ram_b.read_data_top    <= {22'd0, ram_b.read_addr};
            ram_b.read_data_bottom <= 32'h00FF_FFFF;
        end
        if (ram_s.read_en) begin
            ram_s.read_data_top    <= mem_s_top[ram_s.read_addr];
            ram_s.read_data_bottom <= mem_s_bot[ram_s.read_addr];
        end
    end

    // Swap model for the small instance: frame boundaries every FRAME_S cycles from t0_s.
    logic model_toggle, model_pending;
    int   t0_s;

    task automatic test_reset();
        bit found;
        reset_n = 1'b0; reset_s_n = 1'b0; swap_req_b = 1'b0; swap_req_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; reset_s_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (oe_b == 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_reach_display: oe_n low seen=%0b required=1", found);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        checks++;
        if (oe_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_display: oe_n=%0b required=0", oe_b);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({oe_b, lat_b, hclk_b, toggle_b, ram_b.read_en, ack_b} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_async: {oe_n,lat,clk,toggle,read_en,ack}=%b required=100000",
                     {oe_b, lat_b, hclk_b, toggle_b, ram_b.read_en, ack_b});
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({oe_b, lat_b, hclk_b, toggle_b, ram_b.read_en, ack_b, addr_b} !== 10'b1000000000) begin
            errors++;
            $display("FAIL reset_hold: {oe_n,lat,clk,toggle,read_en,ack,addr}=%b required=1000000000",
                     {oe_b, lat_b, hclk_b, toggle_b, ram_b.read_en, ack_b, addr_b});
        end
        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (ram_b.read_en === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || ram_b.read_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_first_read: read_en seen=%0b addr=%0d required seen=1 addr=0",
                     found, ram_b.read_addr);
        end
    endtask

    task automatic test_shift();
        int   edges = 0;
        bit   prev, saw_lat = 1'b0, saw_disp = 1'b0;
        logic [5:0] got, exp;
        prev = hclk_b;
        for (int i = 0; i < 400 && edges < 64; i++) begin
            @(negedge clk);
            if (lat_b) saw_lat = 1'b1;
            if (!oe_b) saw_disp = 1'b1;
            if (hclk_b && !prev) begin
                got = {r0_b, g0_b, b0_b, r1_b, g1_b, b1_b};
                exp = {edges[0], 2'b00, 3'b111};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL shift_pixel col %0d: rgb0rgb1=%b required=%b", edges, got, exp);
                end
                edges++;
            end
            prev = hclk_b;
        end
        checks++;
        if (edges != 64 || saw_lat || saw_disp) begin
            errors++;
            $display("FAIL shift_edges: edges=%0d lat_seen=%0b oe_low_seen=%0b required 64/0/0",
                     edges, saw_lat, saw_disp);
        end
    endtask

    task automatic test_bcm_frame();
        int lat_idx = -1, low = 0, t_first = 0, exp_w;
        bit done = 1'b0;
        for (int i = 0; i < FRAME_B + 3000 && !done; i++) begin
            @(negedge clk);
            if (!oe_b) begin
                low++;
            end else if (low != 0) begin
                exp_w = BASE_B << (lat_idx % BPC_B);
                checks++;
                if (low != exp_w) begin
                    errors++;
                    $display("FAIL bcm_window latch %0d: oe_n low %0d cycles required %0d", lat_idx, low, exp_w);
                end
                low = 0;
            end
            if (lat_b) begin
                lat_idx++;
                if (lat_idx == 0) t_first = cyc;
                checks++;
                if (addr_b !== 4'((lat_idx / BPC_B) % 16)) begin
                    errors++;
                    $display("FAIL bcm_row_addr latch %0d: addr=%0d required=%0d",
                             lat_idx, addr_b, (lat_idx / BPC_B) % 16);
                end
                if (lat_idx == 16 * BPC_B) begin
                    checks++;
                    if (cyc - t_first != FRAME_B) begin
                        errors++;
                        $display("FAIL frame_length: %0d cycles required %0d", cyc - t_first, FRAME_B);
                    end
                    done = 1'b1;
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL frame_timeout: latches seen %0d required %0d", lat_idx + 1, 16 * BPC_B + 1);
        end
    endtask

    task automatic test_random_pixels();
        int   edges = 0, rp, col, plane, row, a;
        bit   prev, found = 1'b0;
        logic [BPP-1:0] ts, bs;
        logic [5:0] got, exp;
        reset_s_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_s_n = 1'b1;
        model_toggle = 1'b0;
        model_pending = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (ram_s.read_en === 1'b1) begin
                found = 1'b1;
                t0_s = cyc;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL small_first_read: read_en seen=0 required=1");
            t0_s = cyc;
        end
        prev = hclk_s;
        for (int i = 0; i < FRAME_S + 200 && edges < 64 * 16 * BPC_S; i++) begin
            @(negedge clk);
            if (hclk_s && !prev) begin
                rp    = edges / 64;
                col   = edges % 64;
                plane = rp % BPC_S;
                row   = rp / BPC_S;
                a     = row * 64 + col;
                ts    = mem_s_top[a] >> plane;
                bs    = mem_s_bot[a] >> plane;
                exp   = {ts[0], ts[BPC_S], ts[2*BPC_S], bs[0], bs[BPC_S], bs[2*BPC_S]};
                got   = {r0_s, g0_s, b0_s, r1_s, g1_s, b1_s};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random_pixel row %0d plane %0d col %0d: rgb0rgb1=%b required=%b",
                             row, plane, col, got, exp);
                end
                edges++;
            end
            prev = hclk_s;
        end
        checks++;
        if (edges != 64 * 16 * BPC_S) begin
            errors++;
            $display("FAIL random_pixel_count: edges=%0d required=%0d", edges, 64 * 16 * BPC_S);
        end
    endtask

    // Runs the small instance cycle by cycle up to until_cyc, pulsing swap_req at req1/req2.
    task automatic run_swaps(input int until_cyc, input int req1, input int req2);
        int c;
        bit exp_ack;
        for (int i = 0; i < 4 * FRAME_S && cyc < until_cyc; i++) begin
            @(negedge clk);
            c = cyc;
            exp_ack = 1'b0;
            if (c > t0_s && (c - t0_s) % FRAME_S == 0 && model_pending) begin
                model_toggle  = ~model_toggle;
                model_pending = 1'b0;
                exp_ack       = 1'b1;
            end
            checks++;
            if ({toggle_s, ack_s} !== {model_toggle, exp_ack}) begin
                errors++;
                $display("FAIL swap cycle %0d: toggle=%0b ack=%0b required toggle=%0b ack=%0b",
                         c - t0_s, toggle_s, ack_s, model_toggle, exp_ack);
            end
            swap_req_s = (c == req1) || (c == req2);
            if (swap_req_s) model_pending = 1'b1;
        end
        swap_req_s = 1'b0;
    endtask

    task automatic test_swap_boundary();
        run_swaps(t0_s + 2 * FRAME_S + 3, t0_s + FRAME_S - 1, -1);
    endtask

    task automatic test_swap_mid_frame();
        int r;
        r = t0_s + 2 * FRAME_S + int'($urandom_range(20, FRAME_S - 20));
        run_swaps(t0_s + 3 * FRAME_S + 3, r, -1);
    endtask

    task automatic test_back_to_back();
        int r1, r2;
        r1 = t0_s + 3 * FRAME_S + int'($urandom_range(5, FRAME_S / 2));
        r2 = t0_s + 3 * FRAME_S + int'($urandom_range(FRAME_S / 2 + 1, FRAME_S - 5));
        run_swaps(t0_s + 4 * FRAME_S + 3, r1, r2);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            mem_s_top[a] = $urandom;
            mem_s_bot[a] = $urandom;
        end
        test_reset();
        test_shift();
        test_bcm_frame();
        test_random_pixels();
        test_swap_boundary();
        test_swap_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hub75_scan_driver.md
Name: hub75_scan_driver

Overview:
- Read-side consumer of sync_pdp_ram. Walks the active frame buffer row-pair by row-pair and serialises pixels onto a HUB75 panel using binary-coded modulation (BCM).
- Panel is 64x32, driven as 16 scan rows. Each RAM read returns the top pixel (row r) and the bottom pixel (row r+16).
- Owns buffer_toggle: swaps buffers only at a frame boundary, on request from the writer side.

Parameters:
- BITS_PER_PIXEL, 32, RAM word width; must be >= 3*BITS_PER_CHANNEL.
- BITS_PER_CHANNEL, 8, number of BCM bit planes. R = data[BPC-1:0], G = data[2*BPC-1:BPC], B = data[3*BPC-1:2*BPC].
- BASE_CYCLES, 4, display time of bit plane 0 in clk cycles. Plane b displays for BASE_CYCLES<<b cycles.

Ports:
- clk  in  1  single system clock; also used as the RAM read_clk.
- reset_n  in  1  asynchronous active-low reset.
- read_addr  out  10  RAM read address = {row[3:0], col[5:0]}.
- read_en  out  1  RAM read enable.
- read_data_top  in  BITS_PER_PIXEL  pixel for row r; valid one cycle after read_en.
- read_data_bottom  in  BITS_PER_PIXEL  pixel for row r+16; same timing as read_data_top.
- buffer_toggle  out  1  selects which RAM buffer is displayed.
- swap_req  in  1  one-cycle pulse from the writer: a new frame is ready.
- swap_ack  out  1  one-cycle pulse in the cycle buffer_toggle flips.
- hub75_r0, hub75_g0, hub75_b0  out  1 each  top-half colour bits.
- hub75_r1, hub75_g1, hub75_b1  out  1 each  bottom-half colour bits.
- hub75_clk  out  1  panel shift clock.
- hub75_lat  out  1  panel latch.
- hub75_oe_n  out  1  panel output enable, active low.
- hub75_addr  out  4  panel row select.

Behaviour:
- Reset values (asynchronous): every output 0 except hub75_oe_n=1. Counters row=0, col=0, plane=0. swap_pending=0. State = S_READ.
- Registered outputs, Moore FSM.
- S_READ (1 cycle): read_en=1, read_addr={row,col}, hub75_clk=0. Next state S_DATA.
- S_DATA (1 cycle): read_en=0. Colour outputs load bit `plane` of each channel from read_data_top and read_data_bottom. hub75_clk=0. Next state S_CLK.
- S_CLK (1 cycle): hub75_clk=1, colour outputs held, col++. If col was 63 (wraps to 0) go to S_BLANK, else go to S_READ.
- Shift cost: 3 cycles per pixel, 192 cycles per row-plane.
- hub75_oe_n=1 in all states except S_DISPLAY.
- S_BLANK (1 cycle): hub75_clk=0, hub75_addr<=row. Next state S_LATCH.
- S_LATCH (1 cycle): hub75_lat=1. Next state S_DISPLAY.
- S_DISPLAY: hub75_oe_n=0 for exactly BASE_CYCLES<<plane cycles; down-counter must be wide enough for BASE_CYCLES<<(BPC-1).
- On leaving S_DISPLAY:
  - plane++.
  - If plane wraps from BPC-1 to 0, then row++.
  - If row wraps from 15 to 0, this is the frame end.
  - Next state S_READ.
- Frame end with swap_pending=1: buffer_toggle flips, swap_ack=1 for that one cycle, swap_pending clears.
- swap_req=1 sets swap_pending in any state. swap_req in the same cycle as the frame end is honoured at that frame end (pending is set-or-consumed, not lost). Multiple requests within one frame collapse into one swap.
- Frame length with defaults: 16 rows * (8*(192+2) + 4*255) = 41152 cycles.
- Reset mid-operation: immediate return to reset values. Panel blanked via oe_n=1. buffer_toggle returns to 0.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles mid-display -> oe_n=1, lat=0, hub75_clk=0, buffer_toggle=0. First post-reset read_addr=0 with read_en=1.
- Shift: RAM model with 1-cycle latency; top pixel at addr a = 0x00000000|a, bottom = 0x00FFFFFF. Plane 0, row 0 -> 64 hub75_clk rising edges. r0 equals bit 0 of col at each edge. r1=g1=b1=1.
- BCM timing: per row, oe_n low windows measured as 4,8,16,...,512 cycles. lat pulses exactly 8 times per row. hub75_addr increments 0..15 then wraps to 0.
- Frame length: the cycle count between consecutive row-0/plane-0 latches is 41152.
- Swap: pulse swap_req mid-frame -> buffer_toggle flips only at the frame end, with a single one-cycle swap_ack. Two swap_req pulses in one frame -> exactly one flip.
- Boundary: swap_req asserted in the frame-end cycle -> flip occurs at that frame end. No flip at the next frame end unless another request arrives.
